// File: rtl/rat_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rat_io_ctrl
// Description : Port-mapped I/O controller between the RAT CPU bus and the
//               board I/O. Provides NUM_OUT writable 8-bit output registers,
//               NUM_IN readable 8-bit input channels, per-input rising-edge
//               event capture into a pending register, a mask register and
//               a registered level interrupt.
// Ports       :
//   CLK        in   1          system clock, rising edge
//   RESET      in   1          synchronous active-high reset
//   PORT_ID    in   8          CPU port address
//   OUT_PORT   in   8          CPU write data
//   IO_STRB    in   1          CPU write strobe (write on every edge it is high)
//   IN_PORT    out  8          CPU read data, combinational from PORT_ID
//   in_data    in   NUM_IN*8   input channel data, channel i = [8i+7:8i]
//   in_event   in   NUM_IN     event lines, synchronous to CLK
//   out_data   out  NUM_OUT*8  output registers, register i = [8i+7:8i]
//   INTERRUPT  out  1          registered |(pending & mask)
// Revision    : 1.0  initial release
// ============================================================================
module rat_io_ctrl #(
  parameter logic [7:0] OUT_BASE    = 8'h40,
  parameter int         NUM_OUT     = 6,
  parameter logic [7:0] IN_BASE     = 8'h10,
  parameter int         NUM_IN      = 4,
  parameter logic [7:0] IRQ_STAT_ID = 8'h20,
  parameter logic [7:0] IRQ_MASK_ID = 8'h21
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             PORT_ID,
  input  logic [7:0]             OUT_PORT,
  input  logic                   IO_STRB,
  output logic [7:0]             IN_PORT,
  input  logic [NUM_IN*8-1:0]    in_data,
  input  logic [NUM_IN-1:0]      in_event,
  output logic [NUM_OUT*8-1:0]   out_data,
  output logic                   INTERRUPT
);

  // Range ends are computed in 9 bits so a block near 8'hFF never wraps.
  localparam logic [8:0] OUT_END = {1'b0, OUT_BASE} + 9'(NUM_OUT);
  localparam logic [8:0] IN_END  = {1'b0, IN_BASE}  + 9'(NUM_IN);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NUM_OUT*8-1:0] out_q,     out_d;
  logic [NUM_IN-1:0]    pending_q, pending_d;
  logic [NUM_IN-1:0]    mask_q,    mask_d;
  logic [NUM_IN-1:0]    prev_q,    prev_d;
  logic                 irq_q,     irq_d;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic       hit_stat;
  logic       hit_mask;
  logic       in_out_rng;
  logic       in_in_rng;
  logic       sel_out;
  logic       sel_in;
  logic [7:0] out_idx;
  logic [7:0] in_idx;

  assign hit_stat   = (PORT_ID == IRQ_STAT_ID);
  assign hit_mask   = (PORT_ID == IRQ_MASK_ID);
  assign in_out_rng = (PORT_ID >= OUT_BASE) && ({1'b0, PORT_ID} < OUT_END);
  assign in_in_rng  = (PORT_ID >= IN_BASE)  && ({1'b0, PORT_ID} < IN_END);

  // Priority: status > mask > output range > input range.
  assign sel_out = in_out_rng && !hit_stat && !hit_mask;
  assign sel_in  = in_in_rng  && !hit_stat && !hit_mask && !in_out_rng;

  assign out_idx = PORT_ID - OUT_BASE;
  assign in_idx  = PORT_ID - IN_BASE;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    if (hit_stat) begin
      rd_data[NUM_IN-1:0] = pending_q;
    end else if (hit_mask) begin
      rd_data[NUM_IN-1:0] = mask_q;
    end else if (sel_out) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_idx == 8'(i)) rd_data = out_q[8*i +: 8];
      end
    end else if (sel_in) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_idx == 8'(i)) rd_data = in_data[8*i +: 8];
      end
    end
  end

  assign IN_PORT = rd_data;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [NUM_IN-1:0] rise;
  logic [NUM_IN-1:0] clr;

  assign rise = in_event & ~prev_q;
  assign clr  = (IO_STRB && hit_stat) ? OUT_PORT[NUM_IN-1:0] : '0;

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (IO_STRB && sel_out && (out_idx == 8'(i))) out_d[8*i +: 8] = OUT_PORT;
    end

    mask_d = mask_q;
    if (IO_STRB && hit_mask && !hit_stat) mask_d = OUT_PORT[NUM_IN-1:0];

    // Set is applied after clear so a same-cycle edge is never lost.
    pending_d = (pending_q & ~clr) | rise;

    prev_d = in_event;

    // Uses the registered pending/mask, giving one cycle from either change.
    irq_d = |(pending_q & mask_q);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
    end
  end

  assign out_data  = out_q;
  assign INTERRUPT = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_rat_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_io_ctrl
// Description : Self-checking bench for rat_io_ctrl. Expected values are
//               queued as stimulus is applied and compared when sampled.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rat_io_ctrl;

  localparam int NUM_OUT = 6;
  localparam int NUM_IN  = 4;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic [7:0]           PORT_ID;
  logic [7:0]           OUT_PORT;
  logic                 IO_STRB;
  logic [7:0]           IN_PORT;
  logic [NUM_IN*8-1:0]  in_data;
  logic [NUM_IN-1:0]    in_event;
  logic [NUM_OUT*8-1:0] out_data;
  logic                 INTERRUPT;

  always #5 CLK = ~CLK;

  rat_io_ctrl #(
    .OUT_BASE    (8'h40),
    .NUM_OUT     (NUM_OUT),
    .IN_BASE     (8'h10),
    .NUM_IN      (NUM_IN),
    .IRQ_STAT_ID (8'h20),
    .IRQ_MASK_ID (8'h21)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .IN_PORT   (IN_PORT),
    .in_data   (in_data),
    .in_event  (in_event),
    .out_data  (out_data),
    .INTERRUPT (INTERRUPT)
  );

  int checks = 0;
  int errors = 0;

  string       sb_tag[$];
  logic [63:0] sb_val[$];

  logic [NUM_OUT*8-1:0] exp_out;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    string       t;
    logic [63:0] v;
    if (sb_val.size() == 0) begin
      check_val("sb_underflow", 64'(sb_val.size()), 64'd1);
    end else begin
      t = sb_tag.pop_front();
      v = sb_val.pop_front();
      check_val(t, obs, v);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] id, input logic [7:0] exp);
    IO_STRB = 1'b0;
    PORT_ID = id;
    sb_push(tag, 64'(exp));
    #1;
    sb_pop(64'(IN_PORT));
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    sb_push(tag, 64'(exp));
    sb_pop(64'(INTERRUPT));
  endtask

  task automatic out_chk(input string tag);
    sb_push(tag, 64'(exp_out));
    sb_pop(64'(out_data));
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    cyc();
    IO_STRB  = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    in_data  = '0;
    in_event = '0;
    exp_out  = '0;
    repeat (2) cyc();
    RESET = 1'b0;

    // Reset state
    out_chk("rst_out");
    irq_chk("rst_irq", 1'b0);
    rd_chk("rst_stat", 8'h20, 8'h00);
    rd_chk("rst_mask", 8'h21, 8'h00);
    cyc();

    // Output write held for two cycles, visible from the first edge
    PORT_ID  = 8'h42;
    OUT_PORT = 8'hA5;
    IO_STRB  = 1'b1;
    out_chk("wr_before_edge");
    cyc();
    exp_out[23:16] = 8'hA5;
    out_chk("wr_edge1");
    cyc();
    out_chk("wr_edge2");
    IO_STRB = 1'b0;
    rd_chk("wr_readback", 8'h42, 8'hA5);
    wr(8'h45, 8'h5A);
    exp_out[47:40] = 8'h5A;
    out_chk("wr_last_reg");
    wr(8'h46, 8'hFF);
    out_chk("wr_past_end");
    wr(8'h3F, 8'h11);
    out_chk("wr_below_base");
    rd_chk("rd_past_end", 8'h46, 8'h00);
    rd_chk("rd_last_reg", 8'h45, 8'h5A);
    cyc();

    // Input channel reads and range boundaries
    in_data = {8'hD4, 8'h99, 8'h3C, 8'h01};
    rd_chk("rd_ch1", 8'h11, 8'h3C);
    rd_chk("rd_unmapped", 8'h7F, 8'h00);
    rd_chk("rd_ch3", 8'h13, 8'hD4);
    cyc();
    rd_chk("rd_in_end", 8'h14, 8'h00);
    rd_chk("rd_ch0", 8'h10, 8'h01);
    rd_chk("rd_in_below", 8'h0F, 8'h00);
    cyc();

    // Enabled event
    wr(8'h21, 8'h04);
    rd_chk("mask_rd", 8'h21, 8'h04);
    in_event = 4'b0100;
    cyc();
    in_event = 4'b0000;
    rd_chk("ev_pend", 8'h20, 8'h04);
    irq_chk("ev_irq_n", 1'b0);
    cyc();
    irq_chk("ev_irq_n1", 1'b1);
    rd_chk("ev_stat", 8'h20, 8'h04);

    // Clear and set on the same bit in the same cycle: set wins
    PORT_ID  = 8'h20;
    OUT_PORT = 8'h04;
    IO_STRB  = 1'b1;
    in_event = 4'b0100;
    cyc();
    IO_STRB  = 1'b0;
    in_event = 4'b0000;
    rd_chk("setwin_pend", 8'h20, 8'h04);
    irq_chk("setwin_irq", 1'b1);
    cyc();
    irq_chk("setwin_irq2", 1'b1);
    wr(8'h20, 8'h04);
    rd_chk("clr_pend", 8'h20, 8'h00);
    irq_chk("clr_irq_lag", 1'b1);
    cyc();
    irq_chk("clr_irq", 1'b0);

    // Masked event, then unmask; held level sets pending only once
    wr(8'h21, 8'h00);
    in_event = 4'b0001;
    cyc();
    rd_chk("msk_pend", 8'h20, 8'h01);
    irq_chk("msk_irq", 1'b0);
    cyc();
    cyc();
    irq_chk("msk_irq_hold", 1'b0);
    wr(8'h21, 8'h01);
    irq_chk("unmask_lag", 1'b0);
    cyc();
    irq_chk("unmask_irq", 1'b1);
    wr(8'h20, 8'h01);
    rd_chk("level_clr", 8'h20, 8'h00);
    cyc();
    irq_chk("level_irq", 1'b0);
    cyc();
    rd_chk("level_once", 8'h20, 8'h00);
    in_event = 4'b0000;
    wr(8'h21, 8'hFF);
    rd_chk("mask_upper", 8'h21, 8'h0F);

    // Reset mid-operation drops a concurrent write
    in_event = 4'b0010;
    cyc();
    in_event = 4'b0000;
    rd_chk("pre_rst_pend", 8'h20, 8'h02);
    cyc();
    irq_chk("pre_rst_irq", 1'b1);
    RESET    = 1'b1;
    PORT_ID  = 8'h40;
    OUT_PORT = 8'h77;
    IO_STRB  = 1'b1;
    cyc();
    RESET   = 1'b0;
    IO_STRB = 1'b0;
    exp_out = '0;
    out_chk("mid_rst_out");
    irq_chk("mid_rst_irq", 1'b0);
    rd_chk("mid_rst_stat", 8'h20, 8'h00);
    rd_chk("mid_rst_mask", 8'h21, 8'h00);
    rd_chk("mid_rst_reg0", 8'h40, 8'h00);

    check_val("sb_drain", 64'(sb_val.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
